// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes, FSM state
// encoding and the request legality rule.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // Stores only exist as SB/SH/SW; the unsigned codes are load-only.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && !addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Picks the addressed byte/half lane out of a memory word and sign- or zero-extends it.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_rdata[8*addr_lo +: 8];
    half_lane = mem_rdata[16*addr_lo[1] +: 16];
    data      = mem_rdata;
    case (funct3)
      F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    data = {{16{half_lane[15]}}, half_lane};
      F3_BU:   data = {24'd0, byte_lane};
      F3_HU:   data = {16'd0, half_lane};
      default: data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns an ALU effective address into a req/ready transaction with
// data memory, with lane steering, load extension, fault and timeout reporting.
//
//   state   | meaning
//   ST_IDLE | waiting for req_valid; request fields latched on acceptance
//   ST_REQ  | mem_req asserted, waiting for mem_ready or timeout
//   ST_DONE | one-cycle done pulse carrying misalign/bus_err
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misalign,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  // Down-counter loaded on entry to REQ; zero marks the last permitted wait cycle.
  localparam logic [3:0] TO_LOAD = 4'(TIMEOUT - 1);

  lsu_state_t       state, state_nxt;
  logic             we_q, mis_q, berr_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] addr_q, wdata_q;
  logic [3:0]       cnt;
  logic [31:0]      load_data;
  logic             legal;

  assign legal = access_legal(req_we, funct3, addr[1:0]);

  load_align u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (addr_q[1:0]),
    .funct3    (f3_q),
    .data      (load_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = legal ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_ready || cnt == 4'd0) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 4'd0;
      rdata   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= funct3;
          addr_q  <= addr;
          wdata_q <= wdata;
          mis_q   <= !legal;
          berr_q  <= 1'b0;
          cnt     <= TO_LOAD;
        end
        ST_REQ: begin
          if (mem_ready) begin
            if (!we_q) rdata <= load_data;
          end else if (cnt == 4'd0) begin
            berr_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          mis_q  <= 1'b0;
          berr_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign misalign = done && mis_q;
  assign bus_err  = done && berr_q;
  assign mem_req  = (state == ST_REQ);
  assign mem_we   = mem_req && we_q;
  assign mem_addr = {addr_q[WIDTH-1:2], 2'b00};

  always_comb begin
    mem_wdata = wdata_q;
    mem_wstrb = 4'b0000;
    case (f3_q[1:0])
      2'b00: begin
        mem_wdata = {4{wdata_q[7:0]}};
        mem_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        mem_wdata = {2{wdata_q[15:0]}};
        mem_wstrb = 4'b0011 << addr_q[1:0];
      end
      default: mem_wstrb = 4'b1111;
    endcase
    if (!mem_we) mem_wstrb = 4'b0000;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, misalign, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic logic ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic f3_ok;
    if (we) f3_ok = (f3 <= 2);
    else    f3_ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
    return f3_ok && (a % acc_size(f3) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] v;
    if (acc_size(f3) == 1) begin
      v = (word >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (acc_size(f3) == 2) begin
      v = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
    int s;
    s = acc_size(f3);
    if (s == 4) return 4'hF;
    return 4'(((1 << s) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (acc_size(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (acc_size(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // One access; memory answers after 'wait_cyc' REQ cycles (>=15 means never).
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] word, input int wait_cyc);
    logic lg;
    int n, exp_n;
    lg = ref_legal(we, f3, a);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = d;
    @(negedge clk);
    req_valid = 1'b0; addr = $urandom; wdata = $urandom;
    chk("busy_after_req", {31'd0, busy}, 32'd1);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      if (n == 0) begin
        chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("mem_wstrb", {28'd0, mem_wstrb}, we ? {28'd0, ref_strb(f3, a)} : 32'd0);
        if (we) chk("mem_wdata", mem_wdata, ref_wdata(f3, d));
      end
      chk("no_done_in_req", {31'd0, done}, 32'd0);
      mem_rdata = $urandom;
      if (n == wait_cyc) begin
        mem_ready = 1'b1; mem_rdata = word;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      n++;
    end
    exp_n = !lg ? 0 : (wait_cyc < 15 ? wait_cyc + 1 : 15);
    chk("req_cycles", n, exp_n);
    if (lg && !we && wait_cyc < 15) model_rdata = ref_load(f3, a, word);
    chk("done", {31'd0, done}, 32'd1);
    chk("misalign", {31'd0, misalign}, {31'd0, !lg});
    chk("bus_err", {31'd0, bus_err}, {31'd0, lg && wait_cyc >= 15});
    chk("rdata", rdata, model_rdata);
    @(negedge clk);
    chk("done_pulse_end", {30'd0, done, busy}, 32'd0);
    chk("flags_clear", {30'd0, misalign, bus_err}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_status", {27'd0, busy, done, misalign, bus_err, mem_req}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem", {mem_addr[31:5], mem_we, mem_wstrb}, 32'd0);
    reset = 1'b0;

    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
    chk("lb_literal", rdata, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0);
    chk("lbu_literal", rdata, 32'h0000_0080);
    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 2);
    chk("lhu_literal", rdata, 32'h0000_80FF);
    access(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'h0, 0);
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h1111_1111, 0);
    access(1'b0, 3'b110, 32'h200, 32'h0, 32'h2222_2222, 0);
    access(1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 0);
    access(1'b0, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 3);
    access(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFE_F00D, 99);
    chk("timeout_rdata_kept", rdata, 32'h1234_5678);

    // Reset while a request is outstanding, with a response arriving at that edge.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    model_rdata = 32'd0;
    chk("reset_mid", {29'd0, mem_req, busy, done}, 32'd0);
    chk("reset_mid_rdata", rdata, 32'd0);
    @(negedge clk);
    chk("reset_no_done", {30'd0, done, busy}, 32'd0);
    access(1'b0, 3'b001, 32'h402, 32'h0, 32'h8001_7FFF, 1);
    chk("post_reset_lh", rdata, 32'hFFFF_8001);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          w;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      w  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 4);
      access(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
